// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: the slot record tracked per
// pipeline stage, and the empty-slot constant used on reset and when a
// bubble is inserted.
package hazard_pkg;

  localparam int REG_W = 4;

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             mem_read;
    logic [REG_W-1:0] dest;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, wb_en: 1'b0, mem_read: 1'b0, dest: '0};

endpackage

// File: rtl/hazard_slot_match.sv
// Compares one in-flight slot against both ID source registers.
// hit      : the slot will write a register the ID instruction reads.
// hit_load : same, and the slot holds a load (data not ready until after MEM).
module hazard_slot_match
  import hazard_pkg::*;
(
  input  slot_t            slot,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             src1_used,
  input  logic             two_src,
  output logic             hit,
  output logic             hit_load
);

  logic writes;
  logic match1;
  logic match2;

  // Qualified source compare; unused sources never create a dependency.
  always_comb begin
    writes   = slot.valid & slot.wb_en;
    match1   = writes & (slot.dest == src1) & src1_used;
    match2   = writes & (slot.dest == src2) & two_src;
    hit      = match1 | match2;
    hit_load = hit & slot.mem_read;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard beside the ID/EXE register. Tracks the destination tags
// of the EXE, MEM and WB instructions, stalls ID on unresolved RAW hazards,
// and exports the MEM/WB tags to the forwarding select logic.
// Build option: define HAZARD_FORWARDING_EN when ALU results are forwarded;
// then only a load immediately followed by its consumer stalls.
// Interface note: there is no valid/ready handshake here; stall is the
// pipeline's ready (active-high "not ready") for the ID instruction, and an
// ID instruction advances into EXE in exactly the cycles where
// id_valid & !stall & !flush.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_src1_used,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic [REG_W-1:0] id_dest,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic [REG_W-1:0] mem_dest,
  output logic             mem_wb_en,
  output logic [REG_W-1:0] wb_dest,
  output logic             wb_wb_en,
  output logic [CNT_W-1:0] stall_cnt
);

  slot_t exe_q;
  slot_t mem_q;
  slot_t wb_q;

  logic exe_hit, exe_hit_load;
  logic mem_hit, mem_hit_load;
  logic wb_hit,  wb_hit_load;
  logic hazard;
  logic issue;
  logic unused_hits;

  hazard_slot_match u_exe_match (
    .slot(exe_q), .src1(id_src1), .src2(id_src2), .src1_used(id_src1_used),
    .two_src(id_two_src), .hit(exe_hit), .hit_load(exe_hit_load)
  );

  hazard_slot_match u_mem_match (
    .slot(mem_q), .src1(id_src1), .src2(id_src2), .src1_used(id_src1_used),
    .two_src(id_two_src), .hit(mem_hit), .hit_load(mem_hit_load)
  );

  hazard_slot_match u_wb_match (
    .slot(wb_q), .src1(id_src1), .src2(id_src2), .src1_used(id_src1_used),
    .two_src(id_two_src), .hit(wb_hit), .hit_load(wb_hit_load)
  );

  // Hazard condition depends on whether ALU results are forwarded.
  always_comb begin
`ifdef HAZARD_FORWARDING_EN
    hazard      = exe_hit_load;
    unused_hits = ^{exe_hit, mem_hit, mem_hit_load, wb_hit, wb_hit_load, WB_BYPASS};
`else
    hazard      = exe_hit | mem_hit | (~WB_BYPASS & wb_hit);
    unused_hits = ^{exe_hit_load, mem_hit_load, wb_hit_load};
`endif
  end

  // Flush wins over stall: a squashed instruction never holds the front end.
  always_comb begin
    stall     = id_valid & ~flush & hazard;
    bubble    = stall | flush;
    issue     = id_valid & ~stall & ~flush;
    mem_dest  = mem_q.dest;
    mem_wb_en = mem_q.valid & mem_q.wb_en;
    wb_dest   = wb_q.dest;
    wb_wb_en  = wb_q.valid & wb_q.wb_en;
  end

  // Advance the slot pipeline; a non-issuing cycle puts a bubble into EXE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_q <= SLOT_EMPTY;
      mem_q <= SLOT_EMPTY;
      wb_q  <= SLOT_EMPTY;
    end else begin
      wb_q  <= mem_q;
      mem_q <= exe_q;
      if (issue) begin
        exe_q <= '{valid: 1'b1, wb_en: id_wb_en, mem_read: id_mem_read, dest: id_dest};
      end else begin
        exe_q <= SLOT_EMPTY;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard. A reference model tracks, per register,
// the first cycle at which an ID reader may proceed, plus a short history of
// issued instructions for the MEM/WB tag outputs. Expected outputs are queued
// by the stimulus process and checked by an independent monitor. A second
// instance with a 2-bit counter covers saturation.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_two_src;
  logic       id_src1_used;
  logic       id_wb_en;
  logic       id_mem_read;
  logic [3:0] id_dest;
  logic       flush;

  logic        stall, bubble, mem_wb_en, wb_wb_en;
  logic [3:0]  mem_dest, wb_dest;
  logic [15:0] stall_cnt;
  logic        s_stall, s_bubble, s_mem_wb_en, s_wb_wb_en;
  logic [3:0]  s_mem_dest, s_wb_dest;
  logic [1:0]  s_stall_cnt;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_two_src(id_two_src), .id_src1_used(id_src1_used),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
    .flush(flush), .stall(stall), .bubble(bubble), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
    .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_two_src(id_two_src), .id_src1_used(id_src1_used),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
    .flush(flush), .stall(s_stall), .bubble(s_bubble), .mem_dest(s_mem_dest),
    .mem_wb_en(s_mem_wb_en), .wb_dest(s_wb_dest), .wb_wb_en(s_wb_wb_en),
    .stall_cnt(s_stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic        mwe;
    logic [3:0]  md;
    logic        wwe;
    logic [3:0]  wd;
  } exp_t;

  logic [$bits(exp_t)-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_t'(exp_q.pop_front());
      chk("stall",      32'(stall),       32'(e.stall));
      chk("bubble",     32'(bubble),      32'(e.bubble));
      chk("stall_cnt",  32'(stall_cnt),   32'(e.cnt));
      chk("mem_wb_en",  32'(mem_wb_en),   32'(e.mwe));
      chk("wb_wb_en",   32'(wb_wb_en),    32'(e.wwe));
      if (e.mwe) chk("mem_dest", 32'(mem_dest), 32'(e.md));
      if (e.wwe) chk("wb_dest",  32'(wb_dest),  32'(e.wd));
      chk("sat_stall",  32'(s_stall),     32'(e.stall));
      chk("sat_cnt",    32'(s_stall_cnt), 32'(e.cnt2));
    end
  end

  // ---------------- reference model ----------------
  // ready_at[r]: first cycle a reader of r in ID may proceed.
  typedef struct {
    logic       wb;
    logic [3:0] dest;
  } rec_t;

  int   ready_at[16];
  int   cyc;
  int   cnt;
  rec_t hist[$];   // [0]=WB, [1]=MEM, [2]=EXE

  function automatic void model_reset();
    rec_t empty;
    empty.wb = 1'b0;
    empty.dest = 4'd0;
    for (int i = 0; i < 16; i++) ready_at[i] = 0;
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(empty);
    cnt = 0;
  endfunction

  // Cycles of extra delay after EXE entry before a reader can proceed.
  function automatic int result_delay(input logic is_load);
`ifdef HAZARD_FORWARDING_EN
    return is_load ? 1 : 0;
`else
    return 2;
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic v, input logic u1, input logic [3:0] s1,
                      input logic two, input logic [3:0] s2, input logic wb,
                      input logic mr, input logic [3:0] d, input logic fl,
                      output logic issued);
    exp_t e;
    logic haz;
    logic st;
    rec_t rec;
    @(posedge clk);
    #1;
    rst_n = ~rst; id_valid = v; id_src1_used = u1; id_src1 = s1; id_two_src = two;
    id_src2 = s2; id_wb_en = wb; id_mem_read = mr; id_dest = d; flush = fl;
    if (rst) model_reset();
    haz = (u1 && ready_at[s1] > cyc) || (two && ready_at[s2] > cyc);
    st = v && !fl && haz;
    e.stall  = st;
    e.bubble = st || fl;
    e.cnt    = (cnt > 65535) ? 16'hffff : 16'(cnt);
    e.cnt2   = (cnt > 3) ? 2'd3 : 2'(cnt);
    e.mwe    = hist[1].wb;
    e.md     = hist[1].dest;
    e.wwe    = hist[0].wb;
    e.wd     = hist[0].dest;
    #1;
    exp_q.push_back(e);
    issued = v && !st && !fl && !rst;
    if (!rst) begin
      rec.wb = issued && wb;
      rec.dest = d;
      if (issued && wb && (cyc + 1 + result_delay(mr) > ready_at[d]))
        ready_at[d] = cyc + 1 + result_delay(mr);
      hist.push_back(rec);
      void'(hist.pop_front());
      if (st) cnt++;
    end
    cyc++;
  endtask

  // Present one instruction until it issues (bounded).
  task automatic issue_instr(input logic u1, input logic [3:0] s1, input logic two,
                             input logic [3:0] s2, input logic wb, input logic mr,
                             input logic [3:0] d);
    logic ok;
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 6) begin
      step(1'b0, 1'b1, u1, s1, two, s2, wb, mr, d, 1'b0, ok);
      n++;
    end
    chk("issue_bound", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    logic ok;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, ok);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic ok;
    rst_n = 1'b0; id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
    id_src1_used = 1'b0; id_wb_en = 1'b0; id_mem_read = 1'b0; id_dest = '0; flush = 1'b0;
    cyc = 0;
    model_reset();

    // Reset held with a real instruction in ID.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0, 4'd4, 1'b0, ok);

    // Load-use: LDR r3 ; ADD r4,r3,r1
    issue_instr(1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3);
    issue_instr(1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0, 4'd4);
    idle(3);

    // ALU-use: ADD r2 ; SUB r5,r2,r2
    issue_instr(1'b1, 4'd0, 1'b1, 4'd1, 1'b1, 1'b0, 4'd2);
    issue_instr(1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0, 4'd5);
    idle(3);

    // Unused source: LDR r3 ; MOV r6,#1 with src1 field = r3
    issue_instr(1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3);
    issue_instr(1'b0, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 4'd6);
    idle(3);

    // Flush in the consumer's ID cycle, then the consumer again.
    issue_instr(1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3);
    step(1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0, 4'd4, 1'b1, ok);
    issue_instr(1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0, 4'd4);
    idle(3);

    // Register 15 as destination and source.
    issue_instr(1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd15);
    issue_instr(1'b1, 4'd15, 1'b0, 4'd0, 1'b1, 1'b0, 4'd7);
    idle(3);

    // Repeated load-use pairs push the 2-bit counter into saturation.
    for (int i = 0; i < 4; i++) begin
      issue_instr(1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd8);
      issue_instr(1'b0, 4'd0, 1'b1, 4'd8, 1'b1, 1'b0, 4'd9);
    end
    idle(2);

    // Reset mid-stall: consumer held in ID while reset asserts.
    issue_instr(1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3);
    step(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, ok);
    step(1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, ok);
    step(1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, ok);

    // Random traffic on a small register window plus r15.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] s1r, s2r, dr;
      s1r = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      s2r = 4'($urandom_range(0, 3));
      dr  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      step(1'b0, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0), s1r,
           ($urandom_range(0, 1) == 1), s2r, ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 2) == 0), dr, ($urandom_range(0, 9) == 0), ok);
    end
    idle(2);

    // Drain: monitor must have consumed every expectation.
    @(posedge clk);
    @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
